// File: rtl/disc_writer.sv
// disc_writer: replays flux timing bytes from acquisition RAM as write pulses.
// One-byte prefetch buffer, interval down-counter, index wait and stream end.
module disc_writer #(
  parameter int PULSE_WIDTH = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic       FD_INDEX_IN,
  output logic       RD_REQ,
  input  logic       RD_ACK,
  input  logic [7:0] RD_DATA,
  output logic       FD_WRDATA,
  output logic       FD_WRGATE,
  output logic       BUSY,
  output logic       DONE,
  output logic       UNDERRUN
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_COUNT, S_WAITIDX, S_END
  } state_t;

  localparam logic [3:0] PW = 4'(PULSE_WIDTH);

  state_t           state_q, state_d;
  logic [7:0]       buf_q;
  logic             bufv_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             pls_q, pls_d;
  logic [3:0]       wcnt_q;
  logic             done_q, done_d;
  logic             under_q, under_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             idx_prev_q;
  logic             idx_rise;
  logic             ev;
  logic             consume;
  logic             fire;

  // 0x00 encodes the longest gap (128 cycles); other codes use bits [6:0].
  function automatic logic [7:0] interval_of(input logic [7:0] b);
    return (b[6:0] == 7'd0) ? 8'd128 : {1'b0, b[6:0]};
  endfunction

  assign idx_rise  = sync_q[SYNC_STAGES-1] & ~idx_prev_q;
  assign RD_REQ    = RUN && (state_q != S_IDLE) && (state_q != S_END) &&
                     (!bufv_q || consume);
  assign FD_WRGATE = (state_q == S_COUNT) || (state_q == S_WAITIDX);
  assign BUSY      = FD_WRGATE;
  assign DONE      = done_q;
  assign UNDERRUN  = under_q;
  assign FD_WRDATA = (wcnt_q != 4'd0);

  // Next-state: events (prime, interval expiry, index edge) consume a byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pls_d   = pls_q;
    done_d  = done_q;
    under_d = under_q;
    ev      = 1'b0;
    consume = 1'b0;
    fire    = 1'b0;
    if (!RUN) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      pls_d   = 1'b0;
      done_d  = 1'b0;
      under_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_PRIME;
        S_PRIME:   consume = bufv_q;
        S_COUNT: begin
          if (cnt_q == 8'd1) ev = 1'b1;
          else               cnt_d = cnt_q - 8'd1;
        end
        S_WAITIDX: ev = idx_rise;
        default:   ;
      endcase
      if (ev) begin
        if (bufv_q) begin
          consume = 1'b1;
          fire    = (state_q == S_COUNT) && pls_q;
        end else begin
          under_d = 1'b1;
          state_d = S_END;
        end
      end
      if (consume) begin
        if (buf_q == 8'hFF) begin
          state_d = S_END;
          done_d  = 1'b1;
        end else if (buf_q == 8'h80) begin
          state_d = S_WAITIDX;
          pls_d   = 1'b0;
        end else begin
          state_d = S_COUNT;
          cnt_d   = interval_of(buf_q);
          pls_d   = |buf_q[6:0];
        end
      end
    end
  end

  // Control state, counters, sticky flags and index synchroniser.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      pls_q      <= 1'b0;
      done_q     <= 1'b0;
      under_q    <= 1'b0;
      sync_q     <= '0;
      idx_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pls_q      <= pls_d;
      done_q     <= done_d;
      under_q    <= under_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], FD_INDEX_IN};
      idx_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Prefetch valid bit: fill and drain may coincide; RUN low flushes.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      bufv_q <= 1'b0;
    end else if (!RUN) begin
      bufv_q <= 1'b0;
    end else if (RD_REQ && RD_ACK) begin
      bufv_q <= 1'b1;
    end else if (consume) begin
      bufv_q <= 1'b0;
    end
  end

  // Prefetch data byte; only meaningful while bufv_q is set.
  always_ff @(posedge CLOCK) begin
    if (RUN && RD_REQ && RD_ACK) buf_q <= RD_DATA;
  end

  // Write-pulse width counter; a new pulse event restarts it.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wcnt_q <= 4'd0;
    end else if (!RUN) begin
      wcnt_q <= 4'd0;
    end else if (fire) begin
      wcnt_q <= PW;
    end else if (wcnt_q != 4'd0) begin
      wcnt_q <= wcnt_q - 4'd1;
    end
  end

endmodule

// File: doc/disc_writer.md
Name: disc_writer

Overview:
- Playback counterpart of the flux acquisition path. Fetches timing bytes from acquisition RAM over a request/acknowledge interface.
- Regenerates flux-transition write pulses on FD_WRDATA at the encoded intervals, all counted in CLOCK cycles.
- Byte coding matches what the acquisition side stores: 7-bit interval, with 0x00 meaning a 128-cycle gap. Adds index-wait and end-of-stream codes.
- Sits between RAM arbitration and the floppy write-data/write-gate drivers.

Parameters:
PULSE_WIDTH, 2, FD_WRDATA high time in CLOCK cycles (legal 1..8)
SYNC_STAGES, 2, flip-flop stages synchronising FD_INDEX_IN (legal 2..3)

Ports:
CLOCK  in  1  system clock, all logic rising-edge
RESET_N  in  1  reset, asynchronous, active-low
RUN  in  1  1 = play stream; 0 = abort/idle
FD_INDEX_IN  in  1  asynchronous index pulse, active-high
RD_REQ  out  1  requests next RAM byte
RD_ACK  in  1  RAM strobe: RD_DATA valid this cycle, one byte consumed
RD_DATA  in  8  timing byte from RAM
FD_WRDATA  out  1  write pulse, active-high
FD_WRGATE  out  1  write gate, active-high
BUSY  out  1  stream in progress
DONE  out  1  end-of-stream reached (sticky until RUN low)
UNDERRUN  out  1  byte not available at interval expiry (sticky until RUN low)

Behaviour:
- Reset (RESET_N low, any time, including mid-stream): state IDLE. All outputs 0. Buffer empty. Counters cleared.
- Byte codes:
  - 0x01..0x7F: interval N with pulse.
  - 0x00: 128-cycle gap, no pulse.
  - 0x80: wait for index rising edge.
  - 0xFF: end of stream.
  - 0x81..0xFE: interval = RD_DATA[6:0] with pulse; 0x81 behaves as 0x01.
- Prefetch buffer: one byte plus valid bit.
  - RD_REQ = RUN && state != IDLE/DONE && (buffer empty || consumed this cycle). Combinational.
  - Fill and drain in the same cycle are legal.
  - RD_ACK while RD_REQ low is ignored.
- FSM states:
  - IDLE: outputs low. When RUN=1, go to PRIME.
  - PRIME: wait for buffer valid. Then consume the byte, set FD_WRGATE=1, BUSY=1, and treat this cycle as event E0. Go to COUNT, WAITIDX or END according to the code.
  - COUNT: down-counter loaded with N (128 for 0x00) at event Ek. Expiry is the event E(k+1) = Ek + N cycles.
    - On expiry with a pulse code: FD_WRDATA is high from cycle E(k+1)+1 for PULSE_WIDTH cycles.
    - On expiry, the next buffered byte is consumed in the same cycle (zero-bubble).
    - Buffer empty at expiry: UNDERRUN=1, FD_WRGATE=0, go to END.
  - WAITIDX: FD_WRGATE held. No pulses. FD_INDEX_IN passes through SYNC_STAGES flip-flops plus an edge register. The cycle in which the synced rising edge is detected is the next event; the next byte is consumed there.
  - END (0xFF or underrun): FD_WRGATE=0, BUSY=0, DONE=1 (end-of-stream only), RD_REQ=0. Held until RUN=0.
- Pulse retrigger: an event with a pulse code while FD_WRDATA is still high restarts the width counter. No gap is inserted.
- First byte: E0 produces no pulse. The first pulse (if any) lands at E1.
- RUN=0 in any state: next cycle state=IDLE, FD_WRDATA=0, FD_WRGATE=0, buffer flushed, DONE/UNDERRUN cleared. A pending RD_ACK in that cycle is discarded.
- Throughput: RAM latency from RD_REQ to RD_ACK must be < the shortest interval. Otherwise UNDERRUN.

Test Plan:
- RUN=1; bytes 0x05,0x03,0xFF with RD_ACK the cycle after RD_REQ -> FD_WRGATE rises at E0; FD_WRDATA rises at E0+6 and E0+9, high 2 cycles each; DONE=1 and FD_WRGATE=0 at the 0xFF event.
- Bytes 0x00,0x02,0xFF -> no pulse at E0+128; single pulse with rising edge at E0+131.
- Bytes 0x80,0x04,0xFF; index edge injected 50 cycles after E0 -> no pulses before the index; pulse rises 4 cycles after the synced edge (+1 register cycle).
- Bytes 0x03 then RD_ACK withheld -> at E0+3, UNDERRUN=1, FD_WRGATE=0, no pulse, DONE=0; dropping RUN clears UNDERRUN.
- Stream 0x7F repeated; RUN dropped mid-pulse, then RESET_N pulsed low mid-COUNT -> FD_WRDATA/FD_WRGATE low the cycle after RUN=0; all outputs 0 immediately on RESET_N low.
- PULSE_WIDTH=4 with bytes 0x02,0x02,0xFF -> pulses retrigger; FD_WRDATA stays continuously high from E1+1 through E2+4.
